// File: rtl/enc_pkg.sv
// Shared definitions for the nibble-Feistel encryption sequencer: state encoding,
// expansion bit map and the default round count.
package enc_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned RoundsDefault = 4;

  // Expansion bit map: E = {d[3],d[0],d[1],d[2],d[1],d[3],d[2],d[0]}
  function automatic logic [7:0] expand(input logic [7:0] d);
    return {d[3], d[0], d[1], d[2], d[1], d[3], d[2], d[0]};
  endfunction

endpackage

// File: rtl/enc_round.sv
// One Feistel round: mixes the low nibble into the high nibble with the round key,
// then swaps the halves.
module enc_round
  import enc_pkg::*;
(
  input  logic [7:0] d,
  input  logic [7:0] k,
  output logic [7:0] d_next
);

  logic [7:0] x;
  logic [3:0] s;

  always_comb begin
    x      = expand(d) ^ k;
    // 4-bit sum; carries out of bit 3 are intentionally dropped
    s      = x[7:4] + x[3:0] + {3'b000, k[0]};
    d_next = {d[3:0], d[7:4] ^ s};
  end

endmodule

// File: rtl/enc_round_sequencer.sv
// Iterative sequencer: accepts a (number, key) pair, applies ROUNDS rounds one per clock
// with a left-rotating key, then holds the ciphertext until the consumer takes it.
module enc_round_sequencer
  import enc_pkg::*;
#(
  parameter int unsigned ROUNDS = RoundsDefault,
  parameter int unsigned CNT_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       number,
  input  logic [7:0]       key,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       enc_number,
  output logic             busy,
  output logic [CNT_W-1:0] round_idx
);

  localparam logic [CNT_W-1:0] LastRound = CNT_W'(ROUNDS - 1);

  state_e           state_q;
  logic [7:0]       data_q;
  logic [7:0]       key_q;
  logic [CNT_W-1:0] round_idx_q;
  logic [7:0]       round_out;

  enc_round u_round (
    .d      (data_q),
    .k      (key_q),
    .d_next (round_out)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      data_q      <= '0;
      key_q       <= '0;
      round_idx_q <= '0;
    end else if (flush) begin
      // Abort keeps data_q/key_q; only control state is cleared
      state_q     <= StIdle;
      round_idx_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            data_q      <= number;
            key_q       <= key;
            round_idx_q <= '0;
            state_q     <= StRun;
          end
        end
        StRun: begin
          data_q      <= round_out;
          key_q       <= {key_q[6:0], key_q[7]};
          round_idx_q <= round_idx_q + CNT_W'(1);
          if (round_idx_q == LastRound) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            round_idx_q <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    in_ready   = (state_q == StIdle);
    busy       = (state_q != StIdle);
    out_valid  = (state_q == StDone);
    enc_number = (state_q == StDone) ? data_q : 8'h00;
    round_idx  = round_idx_q;
  end

endmodule

// File: tb/tb_enc_round_sequencer.sv
// Bench: three sequencers (ROUNDS = 1, 2, 4) share one stimulus stream and are checked
// every cycle against a transaction-level model, plus hand-computed literal expectations.
module tb_enc_round_sequencer;

  localparam int NI = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] number = 8'h00;
  logic [7:0] key = 8'h00;
  logic flush = 1'b0;
  logic out_ready = 1'b1;

  logic       in_ready_w  [NI];
  logic       out_valid_w [NI];
  logic       busy_w      [NI];
  logic [7:0] enc_w       [NI];
  logic [3:0] ridx_w      [NI];

  int rnd [NI] = '{1, 2, 4};

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit stream_on = 1'b0;

  // Model state: busy/done flags, rounds applied so far, and the precomputed ciphertext
  bit         m_busy [NI] = '{0, 0, 0};
  bit         m_done [NI] = '{0, 0, 0};
  int         m_cnt  [NI] = '{0, 0, 0};
  logic [7:0] m_res  [NI] = '{8'h00, 8'h00, 8'h00};
  int         stream_cnt [NI] = '{0, 0, 0};
  int         last_acc   [NI] = '{0, 0, 0};

  always #5 clock = ~clock;

  enc_round_sequencer #(.ROUNDS(1), .CNT_W(4)) u_r1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .number(number), .key(key), .flush(flush), .out_valid(out_valid_w[0]),
    .out_ready(out_ready), .enc_number(enc_w[0]), .busy(busy_w[0]), .round_idx(ridx_w[0])
  );

  enc_round_sequencer #(.ROUNDS(2), .CNT_W(4)) u_r2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .number(number), .key(key), .flush(flush), .out_valid(out_valid_w[1]),
    .out_ready(out_ready), .enc_number(enc_w[1]), .busy(busy_w[1]), .round_idx(ridx_w[1])
  );

  enc_round_sequencer #(.ROUNDS(4), .CNT_W(4)) u_r4 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .number(number), .key(key), .flush(flush), .out_valid(out_valid_w[2]),
    .out_ready(out_ready), .enc_number(enc_w[2]), .busy(busy_w[2]), .round_idx(ridx_w[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Whole-block encryption with plain integer arithmetic; key for round i is key rotl i
  function automatic logic [7:0] ref_enc(input logic [7:0] n, input logic [7:0] k0, input int r);
    int emap [8];
    int d, k32, kk, e, x, s, sh;
    emap = '{3, 0, 1, 2, 1, 3, 2, 0};
    d    = int'(n);
    k32  = int'(k0);
    for (int i = 0; i < r; i++) begin
      sh = i % 8;
      kk = ((k32 << sh) | (k32 >> (8 - sh))) & 255;
      e  = 0;
      for (int j = 0; j < 8; j++) e = (e << 1) | ((d >> emap[j]) & 1);
      x  = e ^ kk;
      s  = ((x >> 4) + (x & 15) + (kk & 1)) % 16;
      d  = ((d & 15) << 4) | (((d >> 4) ^ s) & 15);
    end
    return 8'(d);
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NI; i++) begin
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_cnt[i]  <= 0;
        m_res[i]  <= 8'h00;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (flush) begin
          m_busy[i] <= 1'b0;
          m_done[i] <= 1'b0;
          m_cnt[i]  <= 0;
        end else if (!m_busy[i]) begin
          if (in_valid) begin
            m_busy[i] <= 1'b1;
            m_cnt[i]  <= 0;
            m_res[i]  <= ref_enc(number, key, rnd[i]);
            if (stream_on) begin
              if (stream_cnt[i] > 0)
                check($sformatf("t6_accept_gap_r%0d", rnd[i]), cyc - last_acc[i], rnd[i] + 2);
              stream_cnt[i] <= stream_cnt[i] + 1;
              last_acc[i]   <= cyc;
            end
          end
        end else if (!m_done[i]) begin
          m_cnt[i] <= m_cnt[i] + 1;
          if (m_cnt[i] + 1 == rnd[i]) m_done[i] <= 1'b1;
        end else if (out_ready) begin
          m_busy[i] <= 1'b0;
          m_done[i] <= 1'b0;
          m_cnt[i]  <= 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    for (int i = 0; i < NI; i++) begin
      check($sformatf("r%0d_in_ready", rnd[i]), in_ready_w[i], !m_busy[i]);
      check($sformatf("r%0d_busy", rnd[i]), busy_w[i], m_busy[i]);
      check($sformatf("r%0d_out_valid", rnd[i]), out_valid_w[i], m_done[i]);
      check($sformatf("r%0d_enc_number", rnd[i]), enc_w[i], m_done[i] ? m_res[i] : 8'h00);
      check($sformatf("r%0d_round_idx", rnd[i]), ridx_w[i], m_cnt[i]);
    end
  end

  task automatic wait_valid(input int idx, input int budget);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clock);
      if (out_valid_w[idx]) seen = 1'b1;
    end
    check($sformatf("wait_out_valid_r%0d", rnd[idx]), seen, 1'b1);
  endtask

  task automatic send(input logic [7:0] n, input logic [7:0] k);
    @(negedge clock);
    in_valid = 1'b1;
    number   = n;
    key      = k;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    // Pin the model against hand-computed ciphertexts
    check("model_r1", ref_enc(8'h46, 8'h93, 1), 8'h60);
    check("model_r2", ref_enc(8'h46, 8'h93, 2), 8'h0C);

    #1 reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready_w[2], 1'b1);
    check("rst_out_valid", out_valid_w[2], 1'b0);
    check("rst_busy", busy_w[2], 1'b0);
    check("rst_enc", enc_w[2], 8'h00);
    check("rst_round_idx", ridx_w[2], 4'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Tests 1-3: latency for ROUNDS=1/2, then backpressure while DONE
    out_ready = 1'b0;
    send(8'h46, 8'h93);
    check("t1_r1_not_yet", out_valid_w[0], 1'b0);
    @(negedge clock);
    check("t1_r1_valid", out_valid_w[0], 1'b1);
    check("t1_r1_enc", enc_w[0], 8'h60);
    check("t2_r2_not_yet", out_valid_w[1], 1'b0);
    @(negedge clock);
    check("t2_r2_valid", out_valid_w[1], 1'b1);
    check("t2_r2_enc", enc_w[1], 8'h0C);
    check("t3_r1_held", enc_w[0], 8'h60);
    in_valid = 1'b1;
    number   = 8'hFF;
    key      = 8'h11;
    repeat (2) @(negedge clock);
    for (int c = 0; c < 5; c++) begin
      check("t3_r4_valid_held", out_valid_w[2], 1'b1);
      check("t3_r4_enc_held", enc_w[2], ref_enc(8'h46, 8'h93, 4));
      check("t3_r4_in_ready_low", in_ready_w[2], 1'b0);
      @(negedge clock);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    check("t3_r4_back_idle", busy_w[2], 1'b0);
    check("t3_r4_in_ready", in_ready_w[2], 1'b1);

    // Test 4: flush at round_idx=1
    send(8'hA5, 8'h3C);
    @(negedge clock);
    check("t4_r4_round_idx", ridx_w[2], 4'd1);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("t4_r4_busy", busy_w[2], 1'b0);
    check("t4_r4_in_ready", in_ready_w[2], 1'b1);
    check("t4_r4_round_idx_clr", ridx_w[2], 4'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      check("t4_r4_no_valid", out_valid_w[2], 1'b0);
    end
    send(8'h5A, 8'hC3);
    wait_valid(2, 12);
    check("t4_r4_enc", enc_w[2], ref_enc(8'h5A, 8'hC3, 4));
    repeat (2) @(negedge clock);

    // Test 5: asynchronous reset mid-RUN
    send(8'h46, 8'h93);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("t5_r%0d_in_ready", rnd[i]), in_ready_w[i], 1'b1);
      check($sformatf("t5_r%0d_out_valid", rnd[i]), out_valid_w[i], 1'b0);
      check($sformatf("t5_r%0d_busy", rnd[i]), busy_w[i], 1'b0);
      check($sformatf("t5_r%0d_enc", rnd[i]), enc_w[i], 8'h00);
      check($sformatf("t5_r%0d_round_idx", rnd[i]), ridx_w[i], 4'd0);
    end
    #1 reset = 1'b1;
    send(8'h46, 8'h93);
    wait_valid(0, 5);
    check("t5_r1_restart_enc", enc_w[0], 8'h60);
    repeat (6) @(negedge clock);

    // Test 6: back-to-back stream with out_ready held high
    stream_on = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      in_valid = 1'b1;
      number   = 8'(c * 37 + 11);
      key      = 8'(c * 91 + 5);
    end
    @(negedge clock);
    in_valid  = 1'b0;
    stream_on = 1'b0;
    repeat (8) @(negedge clock);
    check("t6_r4_pairs", stream_cnt[2] >= 4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
